matrix_op_sequencer: RTL and testbench
======================================

// Module: matrix_op_sequencer
// PURPOSE
//  Top-level controller for the 4x4 matrix calculator datapaths (add/sub path, mul path).
//  Accepts an op command, loads operands A and B as 16 nibbles each, then pulses path reset.
//  Launches the selected path, waits for its finish with a timeout, then captures the 160-bit result.
//  Streams the 16 result elements (10b each) to the host over a valid/ready interface.
// PARAMETERS
//  N_ELEM   16  matrix elements per operand/result
//  ELEM_W   4   operand element width
//  RES_W    10  result element width (N_ELEM*RES_W = 160)
//  TIMEOUT  64  max cycles in WAIT before error; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk         in   1    clock
//  rst         in   1    reset, synchronous, active-high
//  cmd_valid   in   1    host command valid
//  cmd_op      in   2    00 add, 01 sub, 10 mul, 11 reserved
//  cmd_ready   out  1    high only in IDLE (and rst low)
//  din_valid   in   1    operand nibble valid
//  din         in   4    operand nibble, element 1 first
//  din_ready   out  1    high in LOAD_A/LOAD_B
//  mat_A       out  64   operand A to paths; element k at [63-4(k-1) -: 4]
//  mat_B       out  64   operand B, same packing
//  path_rst    out  1    synchronous reset to both paths
//  add_en      out  1    launch pulse, add/sub path
//  sign        out  1    1 = subtract; held from LAUNCH through WAIT
//  mul_en      out  1    launch pulse, mul path
//  add_finish  in   1    add/sub path done (sticky until path_rst)
//  add_result  in   160  add/sub path result
//  mul_finish  in   1    mul path done (sticky until path_rst)
//  mul_result  in   160  mul path result
//  res_valid   out  1    result element valid
//  res_data    out  10   result element; element 1 = captured[159:150]
//  res_last    out  1    high with element 16
//  res_ready   in   1    host accepts result element
//  err         out  1    one-cycle pulse: reserved op or timeout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; mat_A/mat_B/captured/counters cleared. Reset mid-op aborts
//   immediately; there is no partial-output pulse; cmd_ready=1 on the first cycle rst is low.
//  IDLE: cmd_ready=1. On cmd_valid: op 11 -> err=1 next cycle, stay IDLE; else latch op,
//   idx=0, -> LOAD_A.
//  LOAD_A/LOAD_B: din_ready=1. Each din_valid writes nibble idx (0 -> bits[63:60]) and idx++.
//   On idx=15 accept: idx=0 and A->LOAD_B, or B->CLEAR. No timeout while loading; gaps allowed.
//  CLEAR: path_rst=1 for exactly 1 cycle -> LAUNCH. This clears the sticky finish of the previous op.
//  LAUNCH: 1 cycle. add_en=1 for add/sub, mul_en=1 for mul. sign=(op==01). wcnt=0 -> WAIT.
//  WAIT: watches only the finish of the selected path; the other path's finish is ignored.
//   finish=1 -> capture selected result into the 160b register in that cycle -> DRAIN.
//   Else wcnt++. When wcnt reaches TIMEOUT-1 with no finish: err=1, -> RECOVER.
//  RECOVER: path_rst=1 for 1 cycle -> IDLE; no result is emitted.
//  DRAIN: res_valid=1, res_data=element idx, res_last=(idx==15). Advance on res_valid&res_ready.
//   res_data is stable while stalled. Last handshake -> IDLE, idx=0.
//  Add path finishes 2 cycles after add_en. Minimum cmd-to-first-result time for an add:
//   1 + 32 + 1 + 1 + 2 = 37 cycles with din_valid held high.
//  Only one op is in flight: cmd_ready=0 outside IDLE. The sequencer never truncates or
//   sign-extends results; RES_W bits pass through.
//  Simultaneous finish and timeout in the same cycle: finish wins.
//  add_en/mul_en are never both high. path_rst is never high in the same cycle as a launch pulse.
// TESTING
//  T1 add, A all 1, B all 2, real add path, res_ready=1 -> 16 beats of 10'd3, res_last on beat 16, no err.
//  T2 sub, A all 7, B all 3 -> sign=1 through WAIT; 16 beats of 10'd4; path_rst pulsed once before add_en.
//  T3 mul, mul_finish tied 0 -> err after 64 WAIT cycles; path_rst pulse; IDLE; res_valid stays 0.
//  T4 add, res_ready toggling 1010... -> each element delivered once, in order, data stable while stalled.
//  T5 cmd_op=11 -> one err pulse, no din_ready; then a valid add completes normally.
//  T6 rst at nibble 9 of B -> all outputs 0; a new add with fresh operands gives correct results.

Source files
------------

// File: rtl/matrix_op_sequencer_if.sv
// Host, operand, path-control and result signals of the matrix op sequencer.
// master: the sequencer itself; slave: host plus add/sub and mul datapaths.
interface matrix_op_sequencer_if #(
    parameter int unsigned N_ELEM = 16,
    parameter int unsigned ELEM_W = 4,
    parameter int unsigned RES_W  = 10
);
    logic                       cmd_valid;
    logic [1:0]                 cmd_op;
    logic                       cmd_ready;
    logic                       din_valid;
    logic [ELEM_W-1:0]          din;
    logic                       din_ready;
    logic [N_ELEM*ELEM_W-1:0]   mat_A;
    logic [N_ELEM*ELEM_W-1:0]   mat_B;
    logic                       path_rst;
    logic                       add_en;
    logic                       sign;
    logic                       mul_en;
    logic                       add_finish;
    logic [N_ELEM*RES_W-1:0]    add_result;
    logic                       mul_finish;
    logic [N_ELEM*RES_W-1:0]    mul_result;
    logic                       res_valid;
    logic [RES_W-1:0]           res_data;
    logic                       res_last;
    logic                       res_ready;
    logic                       err;

    modport master (
        input  cmd_valid, cmd_op, din_valid, din, add_finish, add_result,
               mul_finish, mul_result, res_ready,
        output cmd_ready, din_ready, mat_A, mat_B, path_rst, add_en, sign, mul_en,
               res_valid, res_data, res_last, err
    );

    modport slave (
        output cmd_valid, cmd_op, din_valid, din, add_finish, add_result,
               mul_finish, mul_result, res_ready,
        input  cmd_ready, din_ready, mat_A, mat_B, path_rst, add_en, sign, mul_en,
               res_valid, res_data, res_last, err
    );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Top-level controller for the 4x4 matrix calculator: takes a command, loads operands A and B
// nibble by nibble, resets and launches the selected datapath, waits for it with a timeout,
// then streams the captured 16-element result to the host.
module matrix_op_sequencer #(
    parameter int unsigned N_ELEM  = 16,
    parameter int unsigned ELEM_W  = 4,
    parameter int unsigned RES_W   = 10,
    parameter int unsigned TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  rst,
    matrix_op_sequencer_if.master bus
);
    localparam int unsigned OP_W    = N_ELEM * ELEM_W;
    localparam int unsigned RES_TOT = N_ELEM * RES_W;
    localparam int unsigned IDX_W   = $clog2(N_ELEM);
    localparam int unsigned WCNT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned OPB_W   = $clog2(OP_W);
    localparam int unsigned RESB_W  = $clog2(RES_TOT);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_ELEM - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        StIdle, StLoadA, StLoadB, StClear, StLaunch, StWait, StRecover, StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [OP_W-1:0]     mat_a_q, mat_a_d;
    logic [OP_W-1:0]     mat_b_q, mat_b_d;
    logic [RES_TOT-1:0]  cap_q, cap_d;
    logic                err_q, err_d;

    // Element 1 sits in the most significant slot, so the slot position counts down from idx.
    logic [IDX_W-1:0]    slot;
    logic [OPB_W-1:0]    nib_lsb;
    logic [RESB_W-1:0]   res_lsb;
    logic                fin_sel;
    logic [RES_TOT-1:0]  res_sel;

    assign slot    = IDX_LAST - idx_q;
    assign nib_lsb = OPB_W'(ELEM_W) * OPB_W'(slot);
    assign res_lsb = RESB_W'(RES_W) * RESB_W'(slot);
    // Only the launched path is watched; the other path's finish is ignored.
    assign fin_sel = (op_q == OP_MUL) ? bus.mul_finish : bus.add_finish;
    assign res_sel = (op_q == OP_MUL) ? bus.mul_result : bus.add_result;

    // State and datapath registers; synchronous reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            idx_q   <= '0;
            wcnt_q  <= '0;
            mat_a_q <= '0;
            mat_b_q <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

    // Next-state: command decode, operand load, wait/timeout and result drain sequencing.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;
        cap_d   = cap_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == OP_RSV) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = bus.cmd_op;
                        idx_d   = '0;
                        state_d = StLoadA;
                    end
                end
            end
            StLoadA: begin
                if (bus.din_valid) begin
                    mat_a_d[nib_lsb +: ELEM_W] = bus.din;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = StLoadB;
                    end
                end
            end
            StLoadB: begin
                if (bus.din_valid) begin
                    mat_b_d[nib_lsb +: ELEM_W] = bus.din;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = StClear;
                    end
                end
            end
            StClear: state_d = StLaunch;
            StLaunch: begin
                wcnt_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                // A finish in the timeout cycle still wins.
                if (fin_sel) begin
                    cap_d   = res_sel;
                    idx_d   = '0;
                    state_d = StDrain;
                end else if (wcnt_q == WCNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StRecover;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            StRecover: state_d = StIdle;
            StDrain: begin
                if (bus.res_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; all forced low while rst is asserted.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.din_ready = 1'b0;
        bus.path_rst  = 1'b0;
        bus.add_en    = 1'b0;
        bus.mul_en    = 1'b0;
        bus.sign      = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.res_last  = 1'b0;
        bus.err       = err_q & ~rst;
        bus.mat_A     = mat_a_q;
        bus.mat_B     = mat_b_q;
        if (!rst) begin
            unique case (state_q)
                StIdle:             bus.cmd_ready = 1'b1;
                StLoadA, StLoadB:   bus.din_ready = 1'b1;
                StClear, StRecover: bus.path_rst  = 1'b1;
                StLaunch: begin
                    bus.add_en = (op_q != OP_MUL);
                    bus.mul_en = (op_q == OP_MUL);
                    bus.sign   = (op_q == OP_SUB);
                end
                StWait: bus.sign = (op_q == OP_SUB);
                StDrain: begin
                    bus.res_valid = 1'b1;
                    bus.res_data  = cap_q[res_lsb +: RES_W];
                    bus.res_last  = (idx_q == IDX_LAST);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Bench for matrix_op_sequencer: behavioural add/sub and mul datapaths, randomized operands
// and host back-pressure, expected results computed from the operand arrays the bench drove.
module tb_matrix_op_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_op_sequencer_if bus ();
    matrix_op_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    int nvec = 0;
    int nerr = 0;

    // Operands and result queues of the current operation.
    logic [3:0] opa [16];
    logic [3:0] opb [16];
    logic [9:0] beat_data [$];
    bit         beat_last [$];
    int         accept_cyc;

    // ---------------- behavioural datapaths ----------------
    logic         add_p1, add_fin, mul_fin, mul_busy;
    logic [159:0] add_res, mul_res;
    int           mul_cnt;
    int           mul_lat = 1;
    bit           mul_block = 0;

    function automatic logic [159:0] add_path(input logic [63:0] a, input logic [63:0] b,
                                              input logic s);
        logic [159:0] r;
        for (int k = 0; k < 16; k++) begin
            logic [9:0] ea, eb;
            ea = {6'd0, a[63-4*k -: 4]};
            eb = {6'd0, b[63-4*k -: 4]};
            r[159-10*k -: 10] = s ? ea - eb : ea + eb;
        end
        return r;
    endfunction

    function automatic logic [159:0] mul_path(input logic [63:0] a, input logic [63:0] b);
        logic [159:0] r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int m = 0; m < 4; m++)
                    s += int'(a[63-4*(i*4+m) -: 4]) * int'(b[63-4*(m*4+j) -: 4]);
                r[159-10*(i*4+j) -: 10] = 10'(s);
            end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst || bus.path_rst) begin
            add_p1 <= 1'b0; add_fin <= 1'b0;
            mul_busy <= 1'b0; mul_fin <= 1'b0; mul_cnt <= 0;
        end else begin
            add_p1 <= bus.add_en;
            if (add_p1) add_fin <= 1'b1;
            if (bus.add_en) add_res <= add_path(bus.mat_A, bus.mat_B, bus.sign);
            if (bus.mul_en) begin
                mul_busy <= 1'b1;
                mul_cnt  <= 1;
                mul_res  <= mul_path(bus.mat_A, bus.mat_B);
            end else if (mul_busy && !mul_block) begin
                if (mul_cnt >= mul_lat) begin
                    mul_fin  <= 1'b1;
                    mul_busy <= 1'b0;
                end else begin
                    mul_cnt <= mul_cnt + 1;
                end
            end
        end
    end

    assign bus.add_finish = add_fin;
    assign bus.add_result = add_res;
    assign bus.mul_finish = mul_fin;
    assign bus.mul_result = mul_res;

    // ---------------- event monitor ----------------
    int cyc = 0, prst_cnt = 0, last_prst_cyc = 0, add_en_cnt = 0, mul_en_cnt = 0;
    int add_en_cyc = 0, mul_en_cyc = 0, err_cnt = 0, last_err_cyc = 0, sign_cnt = 0;
    int conflict_cnt = 0, rv_cnt = 0, rv_rise_cyc = 0;
    logic sign_at_launch = 1'b0, rv_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        rv_prev <= bus.res_valid;
        if (bus.path_rst) begin prst_cnt <= prst_cnt + 1; last_prst_cyc <= cyc + 1; end
        if (bus.add_en) begin
            add_en_cnt <= add_en_cnt + 1; add_en_cyc <= cyc + 1; sign_at_launch <= bus.sign;
        end
        if (bus.mul_en) begin mul_en_cnt <= mul_en_cnt + 1; mul_en_cyc <= cyc + 1; end
        if (bus.err) begin err_cnt <= err_cnt + 1; last_err_cyc <= cyc + 1; end
        if (bus.sign) sign_cnt <= sign_cnt + 1;
        if (bus.add_en && bus.mul_en) conflict_cnt <= conflict_cnt + 1;
        if (bus.path_rst && (bus.add_en || bus.mul_en)) conflict_cnt <= conflict_cnt + 1;
        if (bus.res_valid) rv_cnt <= rv_cnt + 1;
        if (bus.res_valid && !rv_prev) rv_rise_cyc <= cyc + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [9:0] ref_elem(input logic [1:0] op, input int k);
        int s;
        if (op == 2'b10) begin
            s = 0;
            for (int m = 0; m < 4; m++) s += int'(opa[(k/4)*4+m]) * int'(opb[m*4+(k%4)]);
            return 10'(s);
        end
        if (op == 2'b01) return 10'((int'(opa[k]) - int'(opb[k]) + 1024) % 1024);
        return 10'(int'(opa[k]) + int'(opb[k]));
    endfunction

    // ---------------- drivers (no checking) ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_operands(input int mode, input logic [3:0] va, input logic [3:0] vb);
        for (int k = 0; k < 16; k++) begin
            opa[k] = (mode == 0) ? va : 4'($urandom_range(15));
            opb[k] = (mode == 0) ? vb : 4'($urandom_range(15));
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, output bit ok);
        int guard;
        guard = 0;
        while (!bus.cmd_ready && guard < 200) begin tick(); guard++; end
        ok = bus.cmd_ready;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        accept_cyc    = cyc + 1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic load_operands(input int gap_pct, input int count, output bit ok);
        int i, guard;
        logic rdy;
        i = 0;
        guard = 0;
        while (i < count && guard < 2000) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                bus.din_valid = 1'b0;
            end else begin
                bus.din_valid = 1'b1;
                bus.din = (i < 16) ? opa[i] : opb[i-16];
            end
            rdy = bus.din_ready;
            tick();
            if (bus.din_valid && rdy) i++;
            guard++;
        end
        bus.din_valid = 1'b0;
        ok = (i == count);
    endtask

    // mode 0: always ready, 1: toggling 1010..., 2: random
    task automatic drain(input int mode, input int budget, output bit unstable);
        bit stalled, got_last;
        logic [9:0] prev;
        logic r;
        stalled = 0; got_last = 0; unstable = 0; prev = '0;
        beat_data.delete();
        beat_last.delete();
        for (int n = 0; n < budget && !got_last; n++) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(n % 2 == 0) : logic'($urandom_range(1));
            bus.res_ready = r;
            if (bus.res_valid) begin
                if (stalled && bus.res_data !== prev) unstable = 1;
                if (r) begin
                    beat_data.push_back(bus.res_data);
                    beat_last.push_back(bus.res_last);
                    got_last = bus.res_last;
                end
            end
            stalled = bus.res_valid && !r;
            prev = bus.res_data;
            tick();
        end
        bus.res_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input int gap, input int mode,
                          output bit ok_cmd, output bit ok_load, output bit unstable);
        send_cmd(op, ok_cmd);
        load_operands(gap, 32, ok_load);
        drain(mode, 400, unstable);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        nvec++; if (bus.cmd_ready !== 1'b0) begin nerr++;
            $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); end
        nvec++; if ({bus.din_ready, bus.path_rst, bus.add_en, bus.mul_en, bus.sign,
                     bus.res_valid, bus.res_last, bus.err} !== 8'd0) begin nerr++;
            $display("FAIL reset_ctrl_outputs: some control output nonzero"); end
        nvec++; if ({bus.mat_A, bus.mat_B, bus.res_data} !== 138'd0) begin nerr++;
            $display("FAIL reset_data: mat_A=%h mat_B=%h res_data=%h want 0",
                     bus.mat_A, bus.mat_B, bus.res_data); end
        rst = 1'b0;
        #1;
        nvec++; if (bus.cmd_ready !== 1'b1) begin nerr++;
            $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic check_beats(input string name, input logic [1:0] op);
        nvec++; if (beat_data.size() != 16) begin nerr++;
            $display("FAIL %s_beats: got %0d want 16", name, beat_data.size()); end
        for (int k = 0; k < beat_data.size() && k < 16; k++) begin
            nvec++; if (beat_data[k] !== ref_elem(op, k) || beat_last[k] !== (k == 15)) begin
                nerr++;
                $display("FAIL %s_elem%0d: got data=%0d last=%b want data=%0d last=%b",
                         name, k, beat_data[k], beat_last[k], ref_elem(op, k), k == 15);
            end
        end
    endtask

    task automatic test_add;
        bit oc, ol, un;
        int e0, p0;
        e0 = err_cnt; p0 = prst_cnt;
        set_operands(0, 4'd1, 4'd2);
        run_op(2'b00, 0, 0, oc, ol, un);
        nvec++; if (!(oc && ol)) begin nerr++;
            $display("FAIL add_handshake: cmd=%b load=%b want 1 1", oc, ol); end
        check_beats("add", 2'b00);
        nvec++; if (beat_data.size() > 0 && beat_data[0] !== 10'd3) begin nerr++;
            $display("FAIL add_value: got %0d want 3", beat_data[0]); end
        nvec++; if (rv_rise_cyc - accept_cyc != 37) begin nerr++;
            $display("FAIL add_latency: got %0d want 37", rv_rise_cyc - accept_cyc); end
        nvec++; if (err_cnt != e0 || prst_cnt - p0 != 1) begin nerr++;
            $display("FAIL add_err_prst: err=%0d prst=%0d want 0 1", err_cnt - e0, prst_cnt - p0); end
    endtask

    task automatic test_sub;
        bit oc, ol, un;
        int s0, a0, m0, p0;
        s0 = sign_cnt; a0 = add_en_cnt; m0 = mul_en_cnt; p0 = prst_cnt;
        set_operands(0, 4'd7, 4'd3);
        run_op(2'b01, 0, 0, oc, ol, un);
        check_beats("sub", 2'b01);
        nvec++; if (sign_at_launch !== 1'b1 || sign_cnt - s0 != 3) begin nerr++;
            $display("FAIL sub_sign: launch=%b cycles=%0d want 1 3", sign_at_launch, sign_cnt - s0); end
        nvec++; if (add_en_cnt - a0 != 1 || mul_en_cnt != m0) begin nerr++;
            $display("FAIL sub_launch: add_en=%0d mul_en=%0d want 1 0",
                     add_en_cnt - a0, mul_en_cnt - m0); end
        nvec++; if (prst_cnt - p0 != 1 || last_prst_cyc != add_en_cyc - 1) begin nerr++;
            $display("FAIL sub_path_rst: pulses=%0d at %0d want 1 at %0d",
                     prst_cnt - p0, last_prst_cyc, add_en_cyc - 1); end
    endtask

    task automatic test_timeout;
        bit oc, ol, un;
        int e0, r0;
        e0 = err_cnt; r0 = rv_cnt;
        mul_block = 1;
        set_operands(1, 4'd0, 4'd0);
        run_op(2'b10, 0, 0, oc, ol, un);
        mul_block = 0;
        nvec++; if (err_cnt - e0 != 1 || last_err_cyc - mul_en_cyc != 65) begin nerr++;
            $display("FAIL timeout_err: pulses=%0d delay=%0d want 1 65",
                     err_cnt - e0, last_err_cyc - mul_en_cyc); end
        nvec++; if (last_prst_cyc != last_err_cyc) begin nerr++;
            $display("FAIL timeout_recover: path_rst at %0d want %0d", last_prst_cyc, last_err_cyc); end
        nvec++; if (rv_cnt != r0 || beat_data.size() != 0 || bus.cmd_ready !== 1'b1) begin nerr++;
            $display("FAIL timeout_idle: res_valid cycles=%0d cmd_ready=%b want 0 1",
                     rv_cnt - r0, bus.cmd_ready); end
    endtask

    task automatic test_backpressure;
        bit oc, ol, un;
        set_operands(1, 4'd0, 4'd0);
        run_op(2'b00, 0, 1, oc, ol, un);
        check_beats("stall", 2'b00);
        nvec++; if (un) begin nerr++;
            $display("FAIL stall_stable: got unstable=1 want 0"); end
    endtask

    task automatic test_reserved;
        bit oc, ol, un;
        int e0;
        e0 = err_cnt;
        send_cmd(2'b11, oc);
        nvec++; if (bus.err !== 1'b1 || bus.din_ready !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rsv_err: err=%b din_ready=%b cmd_ready=%b want 1 0 1",
                     bus.err, bus.din_ready, bus.cmd_ready); end
        tick();
        nvec++; if (bus.err !== 1'b0 || err_cnt - e0 != 1) begin nerr++;
            $display("FAIL rsv_pulse: err=%b pulses=%0d want 0 1", bus.err, err_cnt - e0); end
        set_operands(1, 4'd0, 4'd0);
        run_op(2'b00, 20, 0, oc, ol, un);
        check_beats("rsv_after", 2'b00);
    endtask

    task automatic test_mid_reset;
        bit oc, ol, un;
        set_operands(1, 4'd0, 4'd0);
        send_cmd(2'b00, oc);
        load_operands(0, 25, ol);
        rst = 1'b1;
        tick();
        nvec++; if ({bus.cmd_ready, bus.din_ready, bus.path_rst, bus.add_en, bus.mul_en,
                     bus.res_valid, bus.err} !== 7'd0 || {bus.mat_A, bus.mat_B} !== 128'd0) begin
            nerr++;
            $display("FAIL midrst_outputs: din_ready=%b mat_A=%h want 0 0", bus.din_ready, bus.mat_A);
        end
        rst = 1'b0;
        #1;
        nvec++; if (bus.cmd_ready !== 1'b1) begin nerr++;
            $display("FAIL midrst_ready: got %b want 1", bus.cmd_ready); end
        set_operands(1, 4'd0, 4'd0);
        run_op(2'b00, 0, 0, oc, ol, un);
        check_beats("midrst_add", 2'b00);
    endtask

    task automatic test_random;
        bit oc, ol, un;
        logic [1:0] op;
        for (int t = 0; t < 8; t++) begin
            op = 2'($urandom_range(2));
            mul_lat = int'($urandom_range(1, 30));
            set_operands(1, 4'd0, 4'd0);
            run_op(op, 30, 2, oc, ol, un);
            check_beats("rand", op);
            nvec++; if (un) begin nerr++;
                $display("FAIL rand_stable: iteration %0d data changed while stalled", t); end
        end
        nvec++; if (conflict_cnt != 0) begin nerr++;
            $display("FAIL launch_exclusive: got %0d conflicts want 0", conflict_cnt); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.din_valid = 1'b0;
        bus.din       = 4'd0;
        bus.res_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_timeout();
        test_backpressure();
        test_reserved();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
